// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory/writeback stage.
package mem_stage_pkg;

    // Operation class coming from execute; 2'b11 is not a legal encoding.
    typedef enum logic [1:0] {
        MK_PASS  = 2'd0,
        MK_LOAD  = 2'd1,
        MK_STORE = 2'd2
    } mem_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    // Access size codes.
    localparam logic [1:0] SZ_1B = 2'd0;
    localparam logic [1:0] SZ_2B = 2'd1;
    localparam logic [1:0] SZ_4B = 2'd2;
    localparam logic [1:0] SZ_8B = 2'd3;

    // Byte-strobe pattern for an access at byte offset 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_1B:   return 8'h01;
            SZ_2B:   return 8'h03;
            SZ_4B:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Number of bytes touched by an access of the given size.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for an 8-byte data bus: shifts store data and strobes
// up to the access offset, and shifts load data down with zero-extension.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [1:0]          size,
    input  logic [2:0]          offset,
    input  logic [DATA_W-1:0]   st_data,
    input  logic [DATA_W-1:0]   ld_raw,
    output logic [DATA_W-1:0]   st_wdata,
    output logic [DATA_W/8-1:0] st_strb,
    output logic [DATA_W-1:0]   ld_data
);
    localparam int STRB_W = DATA_W / 8;

    logic [7:0]        mask;
    logic [5:0]        shamt;
    logic [DATA_W-1:0] ld_shift;

    assign mask     = size_mask(size);
    assign shamt    = {offset, 3'b000};
    assign st_strb  = STRB_W'(mask) << offset;
    assign st_wdata = st_data << shamt;
    assign ld_shift = ld_raw >> shamt;

    // Keep only the bytes the access size covers; upper bytes read as zero.
    for (genvar i = 0; i < STRB_W; i++) begin : g_zext
        assign ld_data[8*i +: 8] = mask[i] ? ld_shift[8*i +: 8] : 8'h00;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory/writeback stage: passes ALU results straight to writeback and runs
// one data-memory access (load or store) per instruction over a
// valid/ready request bus with a response-valid return.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int REG_W  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                exe_mem,
    input  logic [1:0]          exe_kind,
    input  logic [1:0]          exe_size,
    input  logic [ADDR_W-1:0]   exe_addr,
    input  logic [DATA_W-1:0]   exe_result,
    input  logic [63:0]         exe_rflags,
    input  logic [REG_W-1:0]    exe_dst,
    input  logic                exe_wb_en,
    output logic                mem_blocked,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic                dmem_req_we,
    output logic [ADDR_W-1:0]   dmem_req_addr,
    output logic [DATA_W-1:0]   dmem_req_wdata,
    output logic [DATA_W/8-1:0] dmem_req_strb,
    input  logic                dmem_resp_valid,
    input  logic [DATA_W-1:0]   dmem_resp_rdata,
    output logic                wb_valid,
    output logic [REG_W-1:0]    wb_dst,
    output logic [DATA_W-1:0]   wb_data,
    output logic [63:0]         wb_rflags,
    output logic                misalign_err
);
    mem_state_t state;

    // Fields captured at accept; execute is free to change its bus later.
    logic [1:0]        cap_size;
    logic [2:0]        cap_off;
    logic [DATA_W-1:0] cap_data;
    logic [63:0]       cap_rflags;
    logic [REG_W-1:0]  cap_dst;
    logic              cap_wb_en;

    logic              is_mem;
    logic [3:0]        end_byte;
    logic              misaligned;

    logic [1:0]          al_size;
    logic [2:0]          al_off;
    logic [DATA_W-1:0]   al_wdata;
    logic [DATA_W/8-1:0] al_strb;
    logic [DATA_W-1:0]   al_ld;

    assign mem_blocked = (state != ST_IDLE);
    assign is_mem      = (exe_kind == MK_LOAD) || (exe_kind == MK_STORE);
    assign end_byte    = {1'b0, exe_addr[2:0]} + size_bytes(exe_size);
    assign misaligned  = (end_byte > 4'd8);

    // Store alignment is needed only at accept (IDLE); load alignment only
    // when the response arrives, so one aligner serves both.
    assign al_size = (state == ST_IDLE) ? exe_size      : cap_size;
    assign al_off  = (state == ST_IDLE) ? exe_addr[2:0] : cap_off;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size     (al_size),
        .offset   (al_off),
        .st_data  (exe_result),
        .ld_raw   (dmem_resp_rdata),
        .st_wdata (al_wdata),
        .st_strb  (al_strb),
        .ld_data  (al_ld)
    );

    // Access sequencer with registered request and writeback outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            cap_size       <= '0;
            cap_off        <= '0;
            cap_data       <= '0;
            cap_rflags     <= '0;
            cap_dst        <= '0;
            cap_wb_en      <= 1'b0;
            dmem_req_valid <= 1'b0;
            dmem_req_we    <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_wdata <= '0;
            dmem_req_strb  <= '0;
            wb_valid       <= 1'b0;
            wb_dst         <= '0;
            wb_data        <= '0;
            wb_rflags      <= '0;
            misalign_err   <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (exe_mem) begin
                        if (!is_mem) begin
                            // PASS, or the illegal kind which never writes.
                            wb_valid  <= exe_wb_en && (exe_kind == MK_PASS);
                            wb_dst    <= exe_dst;
                            wb_data   <= exe_result;
                            wb_rflags <= exe_rflags;
                        end else if (misaligned) begin
                            misalign_err <= 1'b1;
                        end else begin
                            cap_size       <= exe_size;
                            cap_off        <= exe_addr[2:0];
                            cap_data       <= exe_result;
                            cap_rflags     <= exe_rflags;
                            cap_dst        <= exe_dst;
                            cap_wb_en      <= exe_wb_en;
                            dmem_req_valid <= 1'b1;
                            dmem_req_we    <= (exe_kind == MK_STORE);
                            dmem_req_addr  <= {exe_addr[ADDR_W-1:3], 3'b000};
                            dmem_req_wdata <= al_wdata;
                            dmem_req_strb  <= al_strb;
                            state          <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        state          <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmem_resp_valid) begin
                        wb_valid  <= cap_wb_en;
                        wb_dst    <= cap_dst;
                        wb_data   <= dmem_req_we ? cap_data : al_ld;
                        wb_rflags <= cap_rflags;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writebacks and
// requests; a bus responder and a writeback monitor pop and compare.
module tb_mem_stage;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int REG_W  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n = 1'b0;
    logic              exe_mem = 1'b0;
    logic [1:0]        exe_kind = '0;
    logic [1:0]        exe_size = '0;
    logic [63:0]       exe_addr = '0;
    logic [63:0]       exe_result = '0;
    logic [63:0]       exe_rflags = '0;
    logic [3:0]        exe_dst = '0;
    logic              exe_wb_en = 1'b0;
    logic              mem_blocked;
    logic              dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [63:0]       dmem_req_addr, dmem_req_wdata;
    logic [7:0]        dmem_req_strb;
    logic              dmem_resp_valid;
    logic [63:0]       dmem_resp_rdata;
    logic              wb_valid, misalign_err;
    logic [3:0]        wb_dst;
    logic [63:0]       wb_data, wb_rflags;

    mem_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .exe_mem(exe_mem), .exe_kind(exe_kind), .exe_size(exe_size),
        .exe_addr(exe_addr), .exe_result(exe_result), .exe_rflags(exe_rflags),
        .exe_dst(exe_dst), .exe_wb_en(exe_wb_en), .mem_blocked(mem_blocked),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_strb(dmem_req_strb),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
        .wb_rflags(wb_rflags), .misalign_err(misalign_err)
    );

    typedef struct packed { logic [3:0] dst; logic [63:0] data; logic [63:0] rf; } wb_t;
    typedef struct packed { logic we; logic [63:0] addr; logic [63:0] wdata; logic [7:0] strb; } req_t;

    wb_t  exp_wb[$];
    req_t exp_req[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_wb_cyc = 0;
    int   mis_seen = 0;

    // Bus responder controls.
    int          ready_delay = 0;
    int          resp_delay = 0;
    logic [63:0] resp_data = '0;
    bit          manual = 1'b0;
    logic        auto_ready = 1'b0, auto_resp = 1'b0;
    logic        man_ready = 1'b0, man_resp = 1'b0;

    assign dmem_req_ready  = manual ? man_ready : auto_ready;
    assign dmem_resp_valid = manual ? man_resp  : auto_resp;
    assign dmem_resp_rdata = resp_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responder: stalls ready, checks request stability and contents, then
    // returns a response after resp_delay extra cycles.
    initial begin : responder
        int   stall;
        int   rdly;
        bit   pending;
        bit   seen;
        req_t snap, cur, e;
        stall = 0; rdly = 0; pending = 0; seen = 0;
        forever begin
            @(negedge clk);
            auto_ready = 1'b0;
            auto_resp  = 1'b0;
            if (manual) begin
                stall = 0; pending = 0; seen = 0;
            end else if (pending) begin
                if (rdly == 0) begin
                    auto_resp = 1'b1;
                    pending   = 0;
                end else rdly--;
            end else if (dmem_req_valid) begin
                cur = '{dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_strb};
                if (!seen) begin
                    snap = cur;
                    seen = 1;
                end else begin
                    checks++;
                    if (cur !== snap) begin
                        errors++;
                        $display("FAIL req_stable: got %h expected %h", cur, snap);
                    end
                end
                if (stall < ready_delay) stall++;
                else begin
                    auto_ready = 1'b1;
                    stall = 0; seen = 0; pending = 1; rdly = resp_delay;
                    if (exp_req.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL req_unexpected: got addr %h expected no request", dmem_req_addr);
                    end else begin
                        e = exp_req.pop_front();
                        chk("req_we",    64'(dmem_req_we),   64'(e.we));
                        chk("req_addr",  dmem_req_addr,      e.addr);
                        chk("req_wdata", dmem_req_wdata,     e.wdata);
                        chk("req_strb",  64'(dmem_req_strb), 64'(e.strb));
                    end
                end
            end
        end
    end

    // Writeback monitor.
    initial begin : monitor
        wb_t w;
        forever begin
            @(negedge clk);
            if (misalign_err) mis_seen++;
            if (wb_valid) begin
                last_wb_cyc = cyc;
                if (exp_wb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: got dst %0d data %h expected no writeback", wb_dst, wb_data);
                end else begin
                    w = exp_wb.pop_front();
                    chk("wb_dst",    64'(wb_dst), 64'(w.dst));
                    chk("wb_data",   wb_data,     w.data);
                    chk("wb_rflags", wb_rflags,   w.rf);
                end
            end
        end
    end

    // Present an op at the current negedge and hold it until accepted.
    task automatic issue(input logic [1:0] kind, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] res, input logic [63:0] rf, input logic [3:0] dst,
                         input logic wen, output int acc);
        int n;
        exe_mem = 1'b1; exe_kind = kind; exe_size = size; exe_addr = addr;
        exe_result = res; exe_rflags = rf; exe_dst = dst; exe_wb_en = wen;
        n = 0;
        while (mem_blocked && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (mem_blocked) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got blocked after %0d cycles expected accept", n);
        end
        acc = cyc;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mem_blocked || exp_wb.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_blocked || exp_wb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_wb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int a0, a1, a2, blk;
        repeat (3) @(negedge clk);
        chk("rst_wb_valid",  64'(wb_valid),       64'd0);
        chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
        chk("rst_blocked",   64'(mem_blocked),    64'd0);
        chk("rst_wb_data",   wb_data,             64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // PASS back-to-back.
        exp_wb.push_back('{4'd1, 64'h11, 64'h100});
        exp_wb.push_back('{4'd2, 64'h22, 64'h101});
        exp_wb.push_back('{4'd3, 64'h33, 64'h102});
        issue(2'd0, 2'd3, 64'h0, 64'h11, 64'h100, 4'd1, 1'b1, a0);
        chk("pass_blk0", 64'(mem_blocked), 64'd0);
        issue(2'd0, 2'd3, 64'h0, 64'h22, 64'h101, 4'd2, 1'b1, a1);
        chk("pass_blk1", 64'(mem_blocked), 64'd0);
        issue(2'd0, 2'd3, 64'h0, 64'h33, 64'h102, 4'd3, 1'b1, a2);
        chk("pass_blk2", 64'(mem_blocked), 64'd0);
        exe_mem = 1'b0;
        drain();
        chk("pass_gap01", 64'(a1 - a0), 64'd1);
        chk("pass_gap12", 64'(a2 - a1), 64'd1);
        chk("pass_lat",   64'(last_wb_cyc - a2), 64'd1);

        // LOAD 4B at 0x1004.
        resp_data = 64'hAABBCCDD_11223344;
        exp_req.push_back('{1'b0, 64'h1000, 64'h0, 8'hF0});
        exp_wb.push_back('{4'd5, 64'h00000000_AABBCCDD, 64'h200});
        issue(2'd1, 2'd2, 64'h1004, 64'h0, 64'h200, 4'd5, 1'b1, a0);
        exe_mem = 1'b0;
        blk = 0;
        while (mem_blocked && blk < 20) begin
            blk++;
            @(negedge clk);
        end
        chk("load_blk_cycles", 64'(blk), 64'd2);
        @(negedge clk);
        chk("load_lat", 64'(last_wb_cyc - a0), 64'd3);
        drain();

        // STORE 2B at 0x2003 with ready stalled, wb_en=0.
        ready_delay = 4; resp_delay = 1;
        exp_req.push_back('{1'b1, 64'h2000, 64'h000000BEEF000000, 8'h18});
        issue(2'd2, 2'd1, 64'h2003, 64'hBEEF, 64'h300, 4'd6, 1'b0, a0);
        exe_mem = 1'b0;
        drain();
        ready_delay = 0; resp_delay = 0;

        // STORE 1B at 0x2005 with wb_en=1: writes back unshifted data.
        exp_req.push_back('{1'b1, 64'h2000, 64'h00005A0000000000, 8'h20});
        exp_wb.push_back('{4'd7, 64'h5A, 64'h301});
        issue(2'd2, 2'd0, 64'h2005, 64'h5A, 64'h301, 4'd7, 1'b1, a0);
        exe_mem = 1'b0;
        drain();

        // Held instruction: PASS presented while a 1B LOAD is outstanding.
        resp_data = 64'h88776655_44332211;
        exp_req.push_back('{1'b0, 64'h1000, 64'h0, 8'h80});
        exp_wb.push_back('{4'd8, 64'h88, 64'h400});
        exp_wb.push_back('{4'd9, 64'h99, 64'h401});
        issue(2'd1, 2'd0, 64'h1007, 64'h0, 64'h400, 4'd8, 1'b1, a0);
        issue(2'd0, 2'd3, 64'h0, 64'h99, 64'h401, 4'd9, 1'b1, a1);
        exe_mem = 1'b0;
        drain();
        chk("held_accept", 64'(a1 - a0), 64'd3);
        chk("held_wb_lat", 64'(last_wb_cyc - a1), 64'd1);

        // Aligned 8B load.
        resp_data = 64'h01234567_89ABCDEF;
        exp_req.push_back('{1'b0, 64'h3000, 64'h0, 8'hFF});
        exp_wb.push_back('{4'd10, 64'h01234567_89ABCDEF, 64'h500});
        issue(2'd1, 2'd3, 64'h3000, 64'h0, 64'h500, 4'd10, 1'b1, a0);
        exe_mem = 1'b0;
        drain();

        // Misaligned accesses and the illegal kind: no request, no writeback.
        issue(2'd1, 2'd3, 64'h3004, 64'h0, 64'h600, 4'd11, 1'b1, a0);
        chk("mis_no_req", 64'(dmem_req_valid), 64'd0);
        chk("mis_blk",    64'(mem_blocked),    64'd0);
        issue(2'd2, 2'd1, 64'h3007, 64'h1234, 64'h601, 4'd12, 1'b1, a0);
        issue(2'd3, 2'd0, 64'h0, 64'hDEAD, 64'h602, 4'd13, 1'b1, a0);
        exe_mem = 1'b0;
        drain();
        chk("mis_count", 64'(mis_seen), 64'd2);

        // Reset while waiting for a load response; the late response is dropped.
        manual = 1'b1;
        issue(2'd1, 2'd3, 64'h4000, 64'h0, 64'h700, 4'd14, 1'b1, a0);
        exe_mem = 1'b0;
        chk("rw_req_valid", 64'(dmem_req_valid), 64'd1);
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        chk("rw_in_wait", 64'(mem_blocked), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rw_blocked",   64'(mem_blocked),    64'd0);
        chk("rw_req_valid0",64'(dmem_req_valid), 64'd0);
        chk("rw_req_addr",  dmem_req_addr,       64'd0);
        chk("rw_req_strb",  64'(dmem_req_strb),  64'd0);
        chk("rw_wb_dst",    64'(wb_dst),         64'd0);
        chk("rw_wb_data",   wb_data,             64'd0);
        chk("rw_wb_rflags", wb_rflags,           64'd0);
        man_resp = 1'b1;
        @(negedge clk);
        man_resp = 1'b0;
        repeat (3) @(negedge clk);
        manual = 1'b0;

        // Recovery after reset.
        exp_wb.push_back('{4'd12, 64'hC0FFEE, 64'h800});
        issue(2'd0, 2'd3, 64'h0, 64'hC0FFEE, 64'h800, 4'd12, 1'b1, a0);
        exe_mem = 1'b0;
        drain();

        chk("end_wb_queue",  64'(exp_wb.size()),  64'd0);
        chk("end_req_queue", 64'(exp_req.size()), 64'd0);
        chk("end_mis_count", 64'(mis_seen),       64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
